// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit driving the dram_* port.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned half/word accesses.
module mem_lsu #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic        dram_en,
  output logic        dram_wen,
  output logic [31:0] dram_addr,
  output logic [31:0] dram_wdata,
  output logic [3:0]  dram_wmask,
  input  logic [31:0] dram_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [3:0] LAST     = 4'(RD_LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        mis;
  logic        acc;
  logic [1:0]  a;
  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata;
  logic [31:0] shifted;
  logic [31:0] load_ext;

`ifdef LSU_MISALIGN_CHECK_EN
  assign mis = (req_size == 2'b01 && req_addr[0]) ||
               (req_size[1] && req_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  assign a   = addr_q[1:0];
  assign acc = (state_q == S_ACCESS);

  // Byte-lane steering for stores and lane extraction for loads
  always_comb begin
    lane_mask  = 4'b1111;
    lane_wdata = wdata_q;
    shifted    = dram_rdata;
    load_ext   = dram_rdata;
    case (size_q)
      2'b00: begin
        lane_mask  = 4'b0001 << a;
        lane_wdata = {4{wdata_q[7:0]}};
        shifted    = dram_rdata >> {a, 3'b000};
        load_ext   = uns_q ? {24'd0, shifted[7:0]}
                           : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        lane_mask  = a[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_q[15:0]}};
        shifted    = a[1] ? {16'd0, dram_rdata[31:16]} : dram_rdata;
        load_ext   = uns_q ? {16'd0, shifted[15:0]}
                           : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        lane_mask  = 4'b1111;
        lane_wdata = wdata_q;
        shifted    = dram_rdata;
        load_ext   = dram_rdata;
      end
    endcase
  end

  // Request/access/response sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rd_d    = req_rd;
          cnt_d   = 4'd0;
          rdata_d = 32'd0;
          err_d   = mis;
          state_d = mis ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (wen_q) begin
          rdata_d = 32'd0;
          state_d = S_RESP;
        end else if (cnt_q == LAST) begin
          rdata_d = load_ext;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wen_q   <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rd_q    <= 5'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = rst_n && (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_rd    = rd_q;
  assign resp_err   = err_q;
  assign dram_en    = acc;
  assign dram_wen   = acc && wen_q;
  assign dram_addr  = acc ? {addr_q[31:2], 2'b00} : 32'd0;
  assign dram_wdata = acc ? lane_wdata : 32'd0;
  assign dram_wmask = acc ? lane_mask : 4'd0;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed checks of mem_lsu at RD_LATENCY 1 and 4.
// Expected misalign results follow LSU_MISALIGN_CHECK_EN.
module tb_mem_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_wen [2];
  logic [1:0]  req_size [2];
  logic        req_unsigned [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [4:0]  req_rd [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic [4:0]  resp_rd [2];
  logic        resp_err [2];
  logic        dram_en [2];
  logic        dram_wen [2];
  logic [31:0] dram_addr [2];
  logic [31:0] dram_wdata [2];
  logic [3:0]  dram_wmask [2];
  logic [31:0] dram_rdata [2];

  logic [31:0] mem [2][16];

  int n_chk;
  int n_fail;

  mem_lsu #(.RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wen(req_wen[0]), .req_size(req_size[0]),
    .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_rd(req_rd[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_rd(resp_rd[0]),
    .resp_err(resp_err[0]),
    .dram_en(dram_en[0]), .dram_wen(dram_wen[0]),
    .dram_addr(dram_addr[0]), .dram_wdata(dram_wdata[0]),
    .dram_wmask(dram_wmask[0]), .dram_rdata(dram_rdata[0])
  );

  mem_lsu #(.RD_LATENCY(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wen(req_wen[1]), .req_size(req_size[1]),
    .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_rd(req_rd[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_rd(resp_rd[1]),
    .resp_err(resp_err[1]),
    .dram_en(dram_en[1]), .dram_wen(dram_wen[1]),
    .dram_addr(dram_addr[1]), .dram_wdata(dram_wdata[1]),
    .dram_wmask(dram_wmask[1]), .dram_rdata(dram_rdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: masked writes on the edge, combinational reads
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (dram_en[k] && dram_wen[k]) begin
        for (int b = 0; b < 4; b++) begin
          if (dram_wmask[k][b])
            mem[k][dram_addr[k][5:2]][8*b +: 8] <= dram_wdata[k][8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++)
      dram_rdata[k] = mem[k][dram_addr[k][5:2]];
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full request/response exchange; resp_ready held low for `hold` cycles
  task automatic xfer(input int k,
                      input logic wen,
                      input logic [1:0] sz,
                      input logic uns,
                      input logic [31:0] addr,
                      input logic [31:0] wd,
                      input logic [4:0] rd,
                      input int hold,
                      output int ens,
                      output logic [3:0] wm,
                      output logic [31:0] wdo,
                      output logic [31:0] rdata,
                      output logic err);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready[k]), 32'd1);
    req_valid[k]    = 1'b1;
    req_wen[k]      = wen;
    req_size[k]     = sz;
    req_unsigned[k] = uns;
    req_addr[k]     = addr;
    req_wdata[k]    = wd;
    req_rd[k]       = rd;
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'b0;
    ens = 0;
    wm  = 4'd0;
    wdo = 32'd0;
    for (int i = 0; i < 40 && !resp_valid[k]; i++) begin
      if (dram_en[k]) begin
        ens++;
        wm  = dram_wmask[k];
        wdo = dram_wdata[k];
      end
      @(negedge clk);
    end
    check("resp_timeout", 32'(resp_valid[k]), 32'd1);
    rdata = resp_rdata[k];
    err   = resp_err[k];
    check("resp_rd", 32'(resp_rd[k]), 32'(rd));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(resp_valid[k]), 32'd1);
      check("hold_rdata", resp_rdata[k], rdata);
      check("hold_req_ready", 32'(req_ready[k]), 32'd0);
      check("hold_dram_en", 32'(dram_en[k]), 32'd0);
    end
    resp_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[k] = 1'b0;
    check("resp_drop", 32'(resp_valid[k]), 32'd0);
  endtask

  int          ens;
  logic [3:0]  wm;
  logic [31:0] wdo;
  logic [31:0] rdata;
  logic        err;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k]    = 1'b0;
      req_wen[k]      = 1'b0;
      req_size[k]     = 2'b00;
      req_unsigned[k] = 1'b0;
      req_addr[k]     = 32'd0;
      req_wdata[k]    = 32'd0;
      req_rd[k]       = 5'd0;
      resp_ready[k]   = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
    check("rst_resp_rdata", resp_rdata[0], 32'd0);
    check("rst_resp_err", 32'(resp_err[0]), 32'd0);
    check("rst_dram_en", 32'(dram_en[0]), 32'd0);
    check("rst_dram_addr", dram_addr[1], 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready[0]), 32'd1);

    // sw / lw at latency 1
    xfer(0, 1'b1, 2'b10, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 5'd3,
         0, ens, wm, wdo, rdata, err);
    check("sw_en_cycles", 32'(ens), 32'd1);
    check("sw_wmask", 32'(wm), 32'hF);
    check("sw_wdata", wdo, 32'hDEAD_BEEF);
    check("sw_rdata", rdata, 32'd0);
    xfer(0, 1'b0, 2'b10, 1'b0, 32'h8000_0004, 32'd0, 5'd7,
         0, ens, wm, wdo, rdata, err);
    check("lw_en_cycles", 32'(ens), 32'd1);
    check("lw_rdata", rdata, 32'hDEAD_BEEF);

    // sb into preloaded word, then lb / lbu
    xfer(0, 1'b1, 2'b10, 1'b0, 32'h8000_0000, 32'h1122_3344, 5'd1,
         0, ens, wm, wdo, rdata, err);
    xfer(0, 1'b1, 2'b00, 1'b0, 32'h8000_0003, 32'h0000_0080, 5'd2,
         0, ens, wm, wdo, rdata, err);
    check("sb_wmask", 32'(wm), 32'h8);
    check("sb_wdata", wdo, 32'h8080_8080);
    xfer(0, 1'b0, 2'b00, 1'b0, 32'h8000_0003, 32'd0, 5'd4,
         0, ens, wm, wdo, rdata, err);
    check("lb_rdata", rdata, 32'hFFFF_FF80);
    xfer(0, 1'b0, 2'b00, 1'b1, 32'h8000_0003, 32'd0, 5'd5,
         0, ens, wm, wdo, rdata, err);
    check("lbu_rdata", rdata, 32'h0000_0080);
    xfer(0, 1'b0, 2'b10, 1'b0, 32'h8000_0000, 32'd0, 5'd6,
         0, ens, wm, wdo, rdata, err);
    check("sb_merge", rdata, 32'h8022_3344);

    // lh / lhu on both halves
    xfer(0, 1'b1, 2'b10, 1'b0, 32'h8000_0000, 32'h8001_7FFF, 5'd1,
         0, ens, wm, wdo, rdata, err);
    xfer(0, 1'b0, 2'b01, 1'b0, 32'h8000_0002, 32'd0, 5'd8,
         0, ens, wm, wdo, rdata, err);
    check("lh_rdata", rdata, 32'hFFFF_8001);
    xfer(0, 1'b0, 2'b01, 1'b1, 32'h8000_0002, 32'd0, 5'd9,
         0, ens, wm, wdo, rdata, err);
    check("lhu_rdata", rdata, 32'h0000_8001);
    xfer(0, 1'b0, 2'b01, 1'b0, 32'h8000_0000, 32'd0, 5'd10,
         0, ens, wm, wdo, rdata, err);
    check("lh_low_rdata", rdata, 32'h0000_7FFF);

    // latency 4: sh lane mask, then lw with back-pressure
    xfer(1, 1'b1, 2'b10, 1'b0, 32'h8000_000C, 32'hCAFE_F00D, 5'd11,
         0, ens, wm, wdo, rdata, err);
    xfer(1, 1'b1, 2'b10, 1'b0, 32'h8000_0004, 32'h0000_0000, 5'd12,
         0, ens, wm, wdo, rdata, err);
    xfer(1, 1'b1, 2'b01, 1'b0, 32'h8000_0006, 32'hAAAA_1234, 5'd13,
         0, ens, wm, wdo, rdata, err);
    check("sh_en_cycles", 32'(ens), 32'd1);
    check("sh_wmask", 32'(wm), 32'hC);
    check("sh_wdata", wdo, 32'h1234_1234);
    xfer(1, 1'b0, 2'b10, 1'b0, 32'h8000_0004, 32'd0, 5'd14,
         0, ens, wm, wdo, rdata, err);
    check("sh_merge", rdata, 32'h1234_0000);
    xfer(1, 1'b0, 2'b10, 1'b0, 32'h8000_000C, 32'd0, 5'd15,
         5, ens, wm, wdo, rdata, err);
    check("lat4_en_cycles", 32'(ens), 32'd4);
    check("lat4_rdata", rdata, 32'hCAFE_F00D);

    // reset during a store's ACCESS cycle before its write edge
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_wen[0]   = 1'b1;
    req_size[0]  = 2'b10;
    req_addr[0]  = 32'h8000_0004;
    req_wdata[0] = 32'h55AA_55AA;
    req_rd[0]    = 5'd20;
    @(posedge clk);
    #2;
    check("abort_en_before", 32'(dram_en[0]), 32'd1);
    rst_n        = 1'b0;
    req_valid[0] = 1'b0;
    #1;
    check("abort_en_drop", 32'(dram_en[0]), 32'd0);
    check("abort_wen_drop", 32'(dram_wen[0]), 32'd0);
    check("abort_resp_valid", 32'(resp_valid[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_req_ready", 32'(req_ready[0]), 32'd1);
    check("abort_resp_valid2", 32'(resp_valid[0]), 32'd0);
    xfer(0, 1'b0, 2'b10, 1'b0, 32'h8000_0004, 32'd0, 5'd21,
         0, ens, wm, wdo, rdata, err);
    check("abort_mem_kept", rdata, 32'hDEAD_BEEF);

    // misaligned word load
    xfer(0, 1'b0, 2'b10, 1'b0, 32'h8000_0002, 32'd0, 5'd22,
         0, ens, wm, wdo, rdata, err);
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis_en_cycles", 32'(ens), 32'd0);
    check("mis_err", 32'(err), 32'd1);
    check("mis_rdata", rdata, 32'd0);
`else
    check("mis_en_cycles", 32'(ens), 32'd1);
    check("mis_err", 32'(err), 32'd0);
    check("mis_rdata", rdata, 32'h8001_7FFF);
`endif
    xfer(0, 1'b0, 2'b10, 1'b0, 32'h8000_0000, 32'd0, 5'd23,
         0, ens, wm, wdo, rdata, err);
    check("aligned_err", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
